// File: rtl/mul_operand_sequencer_pkg.sv
// Shared definitions for the multiplier operand sequencer: FSM encoding,
// default data width and the minimum legal timeout for a given width.
package mul_operand_sequencer_pkg;

  // Sequencer states, 3-bit encoded.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_LDA   = 3'd2,
    S_LDB   = 3'd3,
    S_WAIT  = 3'd4,
    S_CLR   = 3'd5,
    S_OUT   = 3'd6
  } seq_state_e;

  // Operand/product width of the repeated-addition multiplier.
  localparam int unsigned SEQ_WIDTH = 16;

  // Smallest timeout that still lets a full 2^width-iteration run finish:
  // 2^width additions plus the load/done overhead.
  function automatic longint unsigned timeout_min(input int unsigned width);
    return (64'd1 << width) + 64'd5;
  endfunction

endpackage

// File: rtl/mul_operand_sequencer_timeout_cntr.sv
// Saturating timeout counter. hit is registered and is high while the
// count equals LIMIT-1, so the consumer can act in that same cycle.
module seq_timeout_cntr #(
  parameter int TO_W  = 17,
  parameter int LIMIT = 70000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [TO_W-1:0] LAST = TO_W'(LIMIT - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_nxt;

  assign cnt_nxt = cnt_q + TO_W'(1);

  // Count WAIT cycles; stop at the limit so the counter never wraps.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hit   <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      hit   <= (LAST == '0);
    end else if (en && !hit) begin
      cnt_q <= cnt_nxt;
      hit   <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/mul_operand_sequencer.sv
// Operand sequencer in front of the repeated-addition multiplier: takes an
// operand pair, loads A then B onto the shared bus, waits for done with a
// timeout, clears the multiplier and hands the product downstream.
// TIMEOUT should be at least timeout_min(WIDTH) for full-range operands.
module mul_operand_sequencer
  import mul_operand_sequencer_pkg::*;
#(
  parameter int WIDTH   = SEQ_WIDTH,
  parameter int TO_W    = 17,
  parameter int TIMEOUT = 70000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_bus,
  output logic             mul_clr,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_product,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             to_hit;
  logic             accept;
  logic             zero_op;

  assign accept  = (state_q == S_IDLE) && op_valid;
  assign zero_op = (op_a == '0) || (op_b == '0);

  seq_timeout_cntr #(
    .TO_W  (TO_W),
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == S_LDB),
    .en    (state_q == S_WAIT),
    .hit   (to_hit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (op_valid) state_d = zero_op ? S_OUT : S_START;
      S_START: state_d = S_LDA;
      S_LDA:   state_d = S_LDB;
      S_LDB:   state_d = S_WAIT;
      S_WAIT:  if (mul_done || to_hit) state_d = S_CLR;
      S_CLR:   state_d = S_OUT;
      S_OUT:   if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on accept; result capture on zero shortcut, done or timeout.
  // NOTE: the operand registers are reset too, because b_q drives mul_bus
  // and the bus must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= op_a;
        b_q <= op_b;
        if (zero_op) begin
          res_data <= '0;
          res_err  <= 1'b0;
        end
      end
      if (state_q == S_WAIT) begin
        if (mul_done) begin
          res_data <= mul_product;
          res_err  <= 1'b0;
        end else if (to_hit) begin
          res_data <= '0;
          res_err  <= 1'b1;
        end
      end
    end
  end

  // Outputs decoded from state only; the bus parks on b_q outside the A load
  // so the multiplier never sees a stray value while idle.
  assign op_ready  = (state_q == S_IDLE);
  assign mul_start = (state_q == S_START);
  assign mul_clr   = (state_q == S_CLR);
  assign res_valid = (state_q == S_OUT);
  assign mul_bus   = ((state_q == S_START) || (state_q == S_LDA)) ? a_q : b_q;

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Scoreboard bench for mul_operand_sequencer with a behavioural
// repeated-addition multiplier attached to the bus.
module tb_mul_operand_sequencer;

  localparam int W  = 16;
  localparam int TO = 20;

  typedef struct packed {
    logic [W-1:0] d;
    logic         e;
  } res_t;

  logic         clk, rst_n;
  logic         op_valid, op_ready;
  logic [W-1:0] op_a, op_b;
  logic         mul_start, mul_clr, mul_done;
  logic [W-1:0] mul_bus, mul_product;
  logic         res_valid, res_ready, res_err;
  logic [W-1:0] res_data;

  int   errors = 0;
  int   checks = 0;
  res_t sb[$];
  logic hang;

  mul_operand_sequencer #(.WIDTH(W), .TO_W(17), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .mul_start(mul_start), .mul_bus(mul_bus),
    .mul_clr(mul_clr), .mul_done(mul_done), .mul_product(mul_product),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural multiplier: A on the cycle after start, B the cycle after,
  // then one addition per cycle until the counter empties.
  typedef enum {M_IDLE, M_LA, M_LB, M_RUN, M_DONE} m_e;
  m_e           m_st;
  logic [W-1:0] m_a, m_cnt, m_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= M_IDLE; m_a <= '0; m_cnt <= '0; m_p <= '0;
    end else if (mul_clr) begin
      m_st <= M_IDLE;
    end else begin
      case (m_st)
        M_IDLE: if (mul_start) m_st <= M_LA;
        M_LA:   begin m_a <= mul_bus; m_st <= M_LB; end
        M_LB:   begin m_cnt <= mul_bus; m_p <= '0; m_st <= M_RUN; end
        M_RUN:  if (m_cnt == '0) m_st <= M_DONE;
                else begin m_p <= m_p + m_a; m_cnt <= m_cnt - 1'b1; end
        default: ;
      endcase
    end
  end
  assign mul_done    = (m_st == M_DONE) && !hang;
  assign mul_product = m_p;

  // Result monitor: pops the scoreboard on every result handshake.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got data=%0h err=%0b with no pending pair", res_data, res_err);
      end else begin
        res_t exp;
        exp = sb.pop_front();
        check("res_data", res_data, exp.d);
        check("res_err", res_err, exp.e);
      end
    end
  end

  // Bus/pulse observer: counts start/clr pulses and logs the load sequence.
  int         cyc = 0, start_cnt = 0, clr_cnt = 0, start_cyc = 0, clr_cyc = 0;
  int         clr_at_valid = 0, bidx = 3;
  logic [W-1:0] bus_seq [3];
  logic       rv_prev = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (mul_start) begin start_cnt++; start_cyc = cyc; bidx = 0; end
    if (bidx < 3) begin bus_seq[bidx] = mul_bus; bidx++; end
    if (mul_clr) begin clr_cnt++; clr_cyc = cyc; end
    if (res_valid && !rv_prev) clr_at_valid = clr_cnt;
    rv_prev = res_valid;
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input res_t exp);
    int n = 0;
    while (!op_ready && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (!op_ready) begin errors++; $display("FAIL send_wait: op_ready stuck at 0, required 1"); end
    sb.push_back(exp);
    op_a = a; op_b = b; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !op_ready) && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (sb.size() != 0 || !op_ready) begin
      errors++;
      $display("FAIL drain: %0d results pending, op_ready=%0b, required 0 and 1", sb.size(), op_ready);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_op_ready"},  op_ready,  1);
    check({tag, "_mul_start"}, mul_start, 0);
    check({tag, "_mul_bus"},   mul_bus,   0);
    check({tag, "_mul_clr"},   mul_clr,   0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"},  res_data,  0);
    check({tag, "_res_err"},   res_err,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, c0, n;
    rst_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1; hang = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 3 x 4 through the multiplier.
    s0 = start_cnt; c0 = clr_cnt;
    send(16'd3, 16'd4, '{d: 16'd12, e: 1'b0});
    drain();
    check("t1_start_pulses", start_cnt - s0, 1);
    check("t1_bus_start", bus_seq[0], 3);
    check("t1_bus_lda",   bus_seq[1], 3);
    check("t1_bus_ldb",   bus_seq[2], 4);
    check("t1_clr_before_valid", clr_at_valid - c0, 1);

    // Zero operand: local shortcut, one-cycle latency.
    s0 = start_cnt;
    send(16'd0, 16'd9, '{d: 16'd0, e: 1'b0});
    @(negedge clk);
    check("t2_valid_next_cycle", res_valid, 1);
    drain();
    check("t2_no_start", start_cnt - s0, 0);

    // Truncated product.
    send(16'hFFFF, 16'd2, '{d: 16'hFFFE, e: 1'b0});
    drain();

    // Timeout: model never raises done.
    hang = 1'b1; s0 = start_cnt; c0 = clr_cnt;
    send(16'd5, 16'd7, '{d: 16'd0, e: 1'b1});
    drain();
    hang = 1'b0;
    check("t4_start_to_clr", clr_cyc - start_cyc, 3 + TO);
    check("t4_clr_pulses", clr_cnt - c0, 1);

    // Back-pressure in OUT; a new pair offered meanwhile must be ignored.
    res_ready = 1'b0; s0 = start_cnt;
    send(16'd6, 16'd7, '{d: 16'd42, e: 1'b0});
    n = 0;
    while (!res_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("t5_reached_out", res_valid, 1);
    op_a = 16'd1; op_b = 16'd1; op_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_valid_held", res_valid, 1);
      check("t5_data_held", res_data, 42);
      check("t5_op_ready_low", op_ready, 0);
    end
    @(posedge clk); #1;
    op_valid = 1'b0; res_ready = 1'b1;
    drain();
    repeat (5) @(posedge clk); #1;
    check("t5_stalled_pair_dropped", start_cnt - s0, 1);

    // Asynchronous reset while waiting on the multiplier.
    hang = 1'b1;
    send(16'd5, 16'd7, '{d: 16'd0, e: 1'b1});
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1; hang = 1'b0;
    send(16'd5, 16'd5, '{d: 16'd25, e: 1'b0});
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
